// File: rtl/wav_header_parse.sv
// RIFF/WAVE header walker: validates the fmt chunk, forwards the data chunk as
// little-endian 16-bit samples and publishes rate, channel count and data size.
module wav_header_parse #(
  parameter int unsigned MAX_HDR_BYTES = 4096,
  parameter int unsigned REQ_CHANNELS  = 0
) (
  input  logic        SD_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  mydata,
  input  logic        myvalid,
  output logic [15:0] pcm_data,
  output logic        pcm_valid,
  output logic        hdr_done,
  output logic        hdr_err,
  output logic        eof,
  output logic [31:0] sample_rate,
  output logic [15:0] num_channels,
  output logic [31:0] data_bytes
);

  typedef enum logic [2:0] {
    S_IDLE, S_RIFF, S_CHDR, S_FMT, S_SKIP, S_DATA, S_DONE, S_ERR
  } state_t;

  // Four-character codes as they read once packed little-endian.
  localparam logic [31:0] FCC_RIFF  = 32'h4646_4952;
  localparam logic [31:0] FCC_WAVE  = 32'h4556_4157;
  localparam logic [31:0] FCC_FMT   = 32'h2074_6d66;
  localparam logic [31:0] FCC_DATA  = 32'h6174_6164;
  localparam logic [31:0] HDR_LIMIT = 32'(MAX_HDR_BYTES);
  localparam logic [15:0] REQ_CH    = 16'(REQ_CHANNELS);

  state_t      state, state_next;
  logic [55:0] shreg;
  logic [63:0] shreg_next;
  logic [32:0] idx, idx_inc;
  logic [32:0] sect_len;
  logic [31:0] hdr_cnt, hdr_cnt_inc;
  logic        fmt_seen;
  logic [7:0]  low_byte;
  logic [31:0] magic, chunk_id, chunk_size;
  logic [32:0] chunk_len;
  logic [15:0] field16;
  logic        magic_bad, chan_ok, hdr_state, restart_idx;

  always_comb begin
    // NOTE: every combinational signal is defaulted first so no path can infer a latch.
    shreg_next  = {mydata, shreg};
    chunk_id    = shreg_next[31:0];
    chunk_size  = shreg_next[63:32];
    chunk_len   = {1'b0, chunk_size} + {32'd0, chunk_size[0]};
    field16     = shreg_next[63:48];
    idx_inc     = idx + 33'd1;
    hdr_cnt_inc = (hdr_cnt == '1) ? hdr_cnt : hdr_cnt + 32'd1;
    magic       = idx[3] ? FCC_WAVE : FCC_RIFF;
    // Bytes 4-7 of the RIFF header (file size) are not compared.
    magic_bad   = (idx[3] || !idx[2]) && (mydata != magic[{idx[1:0], 3'b000} +: 8]);
    chan_ok     = (REQ_CH != 16'd0) ? (field16 == REQ_CH)
                                    : (field16 == 16'd1 || field16 == 16'd2);
    hdr_state   = state inside {S_RIFF, S_CHDR, S_FMT, S_SKIP};
    state_next  = state;
    restart_idx = 1'b0;
    if (myvalid) begin
      case (state)
        S_RIFF: begin
          if (magic_bad) state_next = S_ERR;
          else if (idx == 33'd11) state_next = S_CHDR;
        end
        S_CHDR: begin
          if (idx == 33'd7) begin
            if (chunk_id == FCC_FMT) begin
              state_next = (chunk_size < 32'd16) ? S_ERR : S_FMT;
            end else if (chunk_id == FCC_DATA) begin
              if (!fmt_seen) state_next = S_ERR;
              else if (chunk_size == 32'd0) state_next = S_DONE;
              else state_next = S_DATA;
            end else if (chunk_len != 33'd0) begin
              state_next = S_SKIP;
            end
          end
        end
        S_FMT: begin
          if ((idx == 33'd1 && field16 != 16'd1) ||
              (idx == 33'd3 && !chan_ok) ||
              (idx == 33'd15 && field16 != 16'd16)) state_next = S_ERR;
          else if (idx_inc == sect_len) state_next = S_CHDR;
        end
        S_SKIP: if (idx_inc == sect_len) state_next = S_CHDR;
        S_DATA: if (idx_inc == {1'b0, data_bytes}) state_next = S_DONE;
        default: ;
      endcase
      // The byte that dispatches into the data chunk is exempt from the header limit.
      if (hdr_state && hdr_cnt_inc >= HDR_LIMIT && !(state_next inside {S_DATA, S_DONE}))
        state_next = S_ERR;
      // A zero-length skip returns to CHDR without a state change, so restart explicitly.
      restart_idx = (state_next != state) || (state == S_CHDR && idx == 33'd7);
    end
  end

  always_ff @(posedge SD_clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= S_IDLE;
    else if (start) state <= S_RIFF;
    else state <= state_next;
  end

  always_ff @(posedge SD_clk) begin
    if (rst || start) begin
      shreg        <= '0;
      idx          <= '0;
      sect_len     <= '0;
      hdr_cnt      <= '0;
      fmt_seen     <= 1'b0;
      low_byte     <= '0;
      pcm_data     <= '0;
      pcm_valid    <= 1'b0;
      sample_rate  <= '0;
      num_channels <= '0;
      data_bytes   <= '0;
    end else begin
      pcm_valid <= 1'b0;
      if (myvalid && (hdr_state || state == S_DATA)) begin
        shreg <= shreg_next[63:8];
        idx   <= restart_idx ? 33'd0 : idx_inc;
        if (hdr_state) hdr_cnt <= hdr_cnt_inc;
        if (state == S_CHDR && idx == 33'd7) begin
          sect_len <= chunk_len;
          if (state_next inside {S_DATA, S_DONE}) data_bytes <= chunk_size;
        end
        if (state == S_FMT) begin
          if (idx == 33'd3) num_channels <= field16;
          if (idx == 33'd7) sample_rate <= shreg_next[63:32];
          if (state_next == S_CHDR) fmt_seen <= 1'b1;
        end
        if (state == S_DATA) begin
          if (!idx[0]) begin
            low_byte <= mydata;
          end else begin
            pcm_data  <= {mydata, low_byte};
            pcm_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign hdr_done = (state == S_DATA) || (state == S_DONE);
  assign hdr_err  = (state == S_ERR);
  assign eof      = (state == S_DONE);

endmodule
